// File: rtl/ami_wsplit.sv
// AXI4 write master: splits user write requests into INCR bursts that
// respect a max length and an address boundary, merging all BRESPs.
module ami_wsplit #(
    parameter int AXI_DW   = 128,
    parameter int AXI_AW   = 32,
    parameter int AXI_IW   = 8,
    parameter int AXI_LW   = 8,
    parameter int AXI_SW   = 3,
    parameter int AMI_OD   = 4,
    parameter int MAX_BLEN = 16,
    parameter int BOUNDARY = 4096,
    parameter int REQ_LW   = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [AXI_IW-1:0]     usr_req_id,
    input  logic [AXI_AW-1:0]     usr_req_addr,
    input  logic [REQ_LW-1:0]     usr_req_len,
    input  logic                  usr_req_valid,
    output logic                  usr_req_ready,
    input  logic [AXI_DW-1:0]     usr_wdata,
    input  logic [AXI_DW/8-1:0]   usr_wstrb,
    input  logic                  usr_wvalid,
    output logic                  usr_wready,
    output logic [AXI_IW-1:0]     usr_bid,
    output logic [1:0]            usr_bresp,
    output logic                  usr_bvalid,
    input  logic                  usr_bready,
    output logic [AXI_IW-1:0]     AWID,
    output logic [AXI_AW-1:0]     AWADDR,
    output logic [AXI_LW-1:0]     AWLEN,
    output logic [AXI_SW-1:0]     AWSIZE,
    output logic [1:0]            AWBURST,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [AXI_DW-1:0]     WDATA,
    output logic [AXI_DW/8-1:0]   WSTRB,
    output logic                  WLAST,
    output logic                  WVALID,
    input  logic                  WREADY,
    input  logic [AXI_IW-1:0]     BID,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY
);

    localparam int BYTES = AXI_DW / 8;
    localparam int SZ    = $clog2(BYTES);
    localparam int BW    = $clog2(BOUNDARY);
    localparam int CW    = REQ_LW + 1;
    localparam int QW    = AXI_LW + 1;
    localparam int PW    = (AMI_OD > 1) ? $clog2(AMI_OD) : 1;
    localparam int OW    = $clog2(AMI_OD + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} state_t;

    state_t            state, state_n;
    logic [AXI_IW-1:0] id_q;
    logic [AXI_AW-1:0] addr_q;
    logic [CW-1:0]     rem_q;
    logic [1:0]        resp_acc;
    logic [OW-1:0]     outst, outst_nx;
    logic [QW-1:0]     lq [AMI_OD];
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [OW-1:0]     lq_cnt, cnt_nx;
    logic [QW-1:0]     beat;
    logic [QW-1:0]     head;
    logic              aw_v;
    logic [AXI_AW-1:0] aw_a;
    logic [AXI_LW-1:0] aw_l;

    logic              req_hs, aw_hs, w_hs, b_hs;
    logic              push, pop, w_act;
    logic              can_issue, aw_load;
    logic [AXI_AW-1:0] src_addr;
    logic [31:0]       src_rem, bnd, sub_c;
    logic [1:0]        b_sev;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(AMI_OD - 1)) ? '0 : p + PW'(1);
    endfunction

    assign usr_req_ready = (state == IDLE) & ~ARESET;
    assign usr_bvalid    = (state == RESP);
    assign usr_bid       = id_q;
    assign usr_bresp     = resp_acc;

    assign AWID    = id_q;
    assign AWADDR  = aw_a;
    assign AWLEN   = aw_l;
    assign AWSIZE  = AXI_SW'(SZ);
    assign AWBURST = 2'b01;
    assign AWVALID = aw_v;

    assign w_act      = (lq_cnt != '0);
    assign head       = lq[rd_ptr];
    assign WVALID     = usr_wvalid & w_act;
    assign usr_wready = WREADY & w_act;
    assign WDATA      = usr_wdata;
    assign WSTRB      = usr_wstrb;
    assign WLAST      = w_act & (beat == head - QW'(1));
    assign BREADY     = (outst != '0);

    assign req_hs = usr_req_valid & usr_req_ready;
    assign aw_hs  = aw_v & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign b_hs   = BVALID & BREADY;
    assign push   = aw_hs;
    assign pop    = w_hs & WLAST;
    assign b_sev  = (BRESP == 2'b01) ? 2'b00 : BRESP;

    assign outst_nx = outst + OW'(aw_hs) - OW'(b_hs);
    assign cnt_nx   = lq_cnt + OW'(push) - OW'(pop);

    // Size of the next burst: limited by beats left, max length and boundary
    always_comb begin
        src_addr = (state == IDLE) ? usr_req_addr : addr_q;
        src_rem  = (state == IDLE) ? 32'(usr_req_len) + 32'd1 : 32'(rem_q);
        bnd      = (32'(BOUNDARY) - 32'(src_addr[BW-1:0])) >> SZ;
        sub_c    = src_rem;
        if (sub_c > 32'(MAX_BLEN)) sub_c = 32'(MAX_BLEN);
        if (bnd < sub_c) sub_c = bnd;
    end

    assign can_issue = (outst_nx < OW'(AMI_OD)) && (cnt_nx < OW'(AMI_OD));
    assign aw_load   = (state == IDLE) ? req_hs :
                       (state == ISSUE) && (rem_q != '0) &&
                       (!aw_v || AWREADY) && can_issue;

    // State register
    always_ff @(posedge ACLK) begin
        if (ARESET) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (req_hs) state_n = ISSUE;
            ISSUE:   if (aw_hs && rem_q == '0) state_n = DRAIN;
            DRAIN:   if (outst == '0 && lq_cnt == '0) state_n = RESP;
            RESP:    if (usr_bready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Latch the request and load/hold the registered AW channel
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            id_q   <= '0;
            addr_q <= '0;
            rem_q  <= '0;
            aw_v   <= 1'b0;
            aw_a   <= '0;
            aw_l   <= '0;
        end else begin
            if (req_hs) id_q <= usr_req_id;
            if (aw_load) begin
                aw_v   <= 1'b1;
                aw_a   <= src_addr;
                aw_l   <= AXI_LW'(sub_c - 32'd1);
                addr_q <= src_addr + AXI_AW'(sub_c << SZ);
                rem_q  <= CW'(src_rem - sub_c);
            end else if (aw_hs) begin
                aw_v <= 1'b0;
            end
        end
    end

    // Merge burst responses by severity
    always_ff @(posedge ACLK) begin
        if (ARESET)                       resp_acc <= 2'b00;
        else if (req_hs)                  resp_acc <= 2'b00;
        else if (b_hs && b_sev > resp_acc) resp_acc <= b_sev;
    end

    // Outstanding burst counter
    always_ff @(posedge ACLK) begin
        if (ARESET) outst <= '0;
        else        outst <= outst_nx;
    end

    // Burst length queue storage
    always_ff @(posedge ACLK) begin
        if (push) lq[wr_ptr] <= QW'(aw_l) + QW'(1);
    end

    // Queue pointers and W beat counter
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lq_cnt <= '0;
            beat   <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                beat   <= '0;
            end else if (w_hs) begin
                beat <= beat + QW'(1);
            end
            lq_cnt <= cnt_nx;
        end
    end

    a_no_stray_b: assert property (@(posedge ACLK) disable iff (ARESET)
        !(BVALID && outst == '0));

    a_bid_known: assert property (@(posedge ACLK) disable iff (ARESET)
        BVALID |-> !$isunknown(BID));

endmodule
